// File: rtl/alu_share_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_pkg
// Shared definitions for the ALU-sharing arbiter: opcode encodings and the
// controller state type.
//
// Contents:
//   OP_AND, OP_OR, OP_ADD, OP_SUB  3-bit opcode constants (100..111 illegal)
//   state_t                        2-bit controller state encoding
//
// Optional build macro used by the design files: ALU_SHARE_ARB_ILLEGAL_OP_EN
// ---------------------------------------------------------------------------
package alu_share_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// ---------------------------------------------------------------------------
// alu_rr_pick
// Combinational round-robin picker. Scans the valid vector starting at ptr
// and moving upward, wrapping from NREQ-1 back to 0, and reports the first
// valid requester it finds.
//
// Ports:
//   valid       in   NREQ  request valid vector
//   ptr         in   IDW   index the scan starts from
//   gnt_onehot  out  NREQ  one-hot grant (all zero when nothing is valid)
//   gnt_idx     out  IDW   binary index of the granted requester
//   any         out  1     at least one requester is valid
// ---------------------------------------------------------------------------
module alu_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  // Walk NREQ positions beginning at ptr. The modulo keeps the index inside
  // 0..NREQ-1 even when ptr lands on a non-valid requester or NREQ is not a
  // power of two, so the wrap is always correct. The first hit wins and
  // later hits are ignored via the any flag.
  always_comb begin
    int idx;
    idx        = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && valid[idx]) begin
        any             = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
// Shares one WIDTH-bit ALU (AND, OR, ADD, SUB) among NREQ requesters. A
// round-robin arbiter accepts one request at a time in IDLE, the ALU result
// is registered in EXEC, and the tagged response is held in RESP until the
// consumer takes it. One operation per 3 cycles at best; accept to
// rsp_valid is 2 cycles.
//
// Ports:
//   clk         in   1           rising-edge clock
//   rst_n       in   1           asynchronous active-low reset
//   req_valid   in   NREQ        per-requester request valid
//   req_ready   out  NREQ        per-requester accept (at most one high)
//   req_a       in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b       in   NREQ*WIDTH  operand B, same packing
//   req_op      in   NREQ*3      opcode, requester i at [i*3 +: 3]
//   rsp_valid   out  1           response valid
//   rsp_ready   in   1           response consumer ready
//   rsp_id      out  IDW         requester that produced the response
//   rsp_result  out  WIDTH       ALU result
//   rsp_carry   out  1           ADD carry-out / SUB borrow, 0 otherwise
//   rsp_err     out  1           illegal-opcode flag
//
// Build macro: ALU_SHARE_ARB_ILLEGAL_OP_EN
//   defined   -> opcodes 100..111 raise rsp_err
//   undefined -> rsp_err is tied to 0
// ---------------------------------------------------------------------------
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_err
);

  state_t           state;
  state_t           state_next;
  logic [IDW-1:0]   rr_ptr;
  logic             accept;

  logic [NREQ-1:0]  gnt_onehot;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;

  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [2:0]       cap_op;
  logic [IDW-1:0]   cap_id;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_err;

  alu_rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .any       (gnt_any)
  );

  // Controller state register. Reset returns to IDLE from any state, which
  // also abandons whatever request had been captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake logic. The grant is only exposed in IDLE, and
  // is additionally masked by rst_n so req_ready stays low while reset is
  // held even though the state register already reads IDLE. A request
  // transfers in the same cycle req_ready is high. RESP never grants, so a
  // new request waits for the following IDLE cycle.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_any && rst_n) begin
          req_ready  = gnt_onehot;
          accept     = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The ALU works only from the captured operands, so requester inputs
  // changing after the accept cycle cannot disturb the result. ADD and SUB
  // are evaluated one bit wider so the top bit is directly the carry-out or
  // the unsigned borrow. Illegal opcodes fall through to zero result/carry.
  always_comb begin
    sum        = {1'b0, cap_a} + {1'b0, cap_b};
    diff       = {1'b0, cap_a} - {1'b0, cap_b};
    alu_result = '0;
    alu_carry  = 1'b0;
    case (cap_op)
      OP_AND:  alu_result = cap_a & cap_b;
      OP_OR:   alu_result = cap_a | cap_b;
      OP_ADD:  {alu_carry, alu_result} = sum;
      OP_SUB:  {alu_carry, alu_result} = diff;
      default: begin
      end
    endcase
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
    alu_err = cap_op[2];
`else
    alu_err = 1'b0;
`endif
  end

  // Datapath registers. On accept the granted requester's fields are
  // captured and the round-robin pointer moves just past the winner, which
  // is what bounds every waiting requester to NREQ grants. EXEC registers
  // the tagged result; RESP holds it untouched until the consumer is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_op     <= '0;
      cap_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        cap_a  <= req_a[gnt_idx*WIDTH +: WIDTH];
        cap_b  <= req_b[gnt_idx*WIDTH +: WIDTH];
        cap_op <= req_op[gnt_idx*3 +: 3];
        cap_id <= gnt_idx;
        rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == ST_EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= cap_id;
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_err    <= alu_err;
      end
      if (state == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arb
// Directed bench for alu_share_arb (NREQ=4, WIDTH=8). Stimulus pushes the
// hand-computed response into a queue; an independent monitor pops and
// compares on every response handshake, and also watches grant shape and
// accept-to-valid latency.
// Build macro honoured: ALU_SHARE_ARB_ILLEGAL_OP_EN
// ---------------------------------------------------------------------------
module tb_alu_share_arb;
  import alu_share_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
  localparam logic ILLEGAL_ERR = 1'b1;
`else
  localparam logic ILLEGAL_ERR = 1'b0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_carry;
  logic                  rsp_err;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             err;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   acceptCycle = 0;
  logic [NREQ-1:0] prevReady = '0;
  logic prevValid = 1'b0;

  alu_share_arb #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err)
  );

  // Free-running clock and a cycle counter used for latency/spacing checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int id, input logic [7:0] result,
                         input logic carry, input logic err);
    exp_t e;
    e.id     = IDW'(id);
    e.result = result;
    e.carry  = carry;
    e.err    = err;
    expQ.push_back(e);
  endtask

  task automatic driveReq(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_op[id*3 +: 3]        = op;
    req_valid[id]            = 1'b1;
  endtask

  // Wait (bounded) for requester id to be granted, then drop its valid
  // just after the accepting edge.
  task automatic waitGrant(input int id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[id] && n < 40);
    checkOutput($sformatf("grant_req%0d", id), 32'(req_ready[id]), 1);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  // Wait (bounded) until every expected response has been consumed.
  task automatic waitDrain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((expQ.size() != 0 || rsp_valid) && n < 60);
    checkOutput("drain", 32'(expQ.size()), 0);
  endtask

  // One complete transaction from a single requester.
  task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op, input logic [7:0] expResult,
                               input logic expCarry, input logic expErr);
    @(posedge clk);
    #1;
    pushExp(id, expResult, expCarry, expErr);
    driveReq(id, a, b, op);
    waitGrant(id);
    waitDrain();
  endtask

  // Monitor: grant shape every cycle, accept-to-valid latency, and the
  // scoreboard pop on each response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      checkOutput("req_ready_onehot", 32'($countones(req_ready) <= 1), 1);
      checkOutput("req_ready_pulse", 32'(req_ready & prevReady), 0);
      if (|(req_ready & req_valid)) acceptCycle = cycle;
      if (rsp_valid && !prevValid) checkOutput("latency", 32'(cycle - acceptCycle), 2);
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_rsp", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
          checkOutput("rsp_result", 32'(rsp_result), 32'(e.result));
          checkOutput("rsp_carry", 32'(rsp_carry), 32'(e.carry));
          checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
    prevReady = req_ready;
    prevValid = rsp_valid;
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int n;
    int gntCycle [5];
    int rrOrder [5];
    logic [WIDTH-1:0] holdResult;
    logic [IDW-1:0]   holdId;
    logic             holdCarry;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    rrOrder   = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 0);
    checkOutput("reset_rsp_result", 32'(rsp_result), 0);
    checkOutput("reset_rsp_carry", 32'(rsp_carry), 0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single ops (rr_ptr: 0 -> 3 -> 2 -> 0 -> 1 -> 3 -> 1)
    applyStimulus(2, 8'hF0, 8'h20, OP_ADD, 8'h10, 1'b1, 1'b0);
    applyStimulus(1, 8'h05, 8'h07, OP_SUB, 8'hFE, 1'b1, 1'b0);
    applyStimulus(3, 8'h07, 8'h05, OP_SUB, 8'h02, 1'b0, 1'b0);
    applyStimulus(0, 8'hFF, 8'h01, 3'b110, 8'h00, 1'b0, ILLEGAL_ERR);
    applyStimulus(2, 8'hCC, 8'hAA, OP_AND, 8'h88, 1'b0, 1'b0);
    // rr_ptr is 3 here, only requester 0 valid: scan must wrap
    applyStimulus(0, 8'h0F, 8'h30, OP_OR, 8'h3F, 1'b0, 1'b0);

    // Backpressure: requester 1 held in RESP while requester 3 waits
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    pushExp(1, 8'h00, 1'b1, 1'b0);
    driveReq(1, 8'h80, 8'h80, OP_ADD);
    waitGrant(1);
    pushExp(3, 8'h0F, 1'b0, 1'b0);
    driveReq(3, 8'h10, 8'h01, OP_SUB);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 1);
    holdResult = rsp_result;
    holdId     = rsp_id;
    holdCarry  = rsp_carry;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_valid_hold", 32'(rsp_valid), 1);
      checkOutput("bp_result_hold", 32'(rsp_result), 32'(holdResult));
      checkOutput("bp_id_hold", 32'(rsp_id), 32'(holdId));
      checkOutput("bp_carry_hold", 32'(rsp_carry), 32'(holdCarry));
      checkOutput("bp_no_grant", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_valid_drop", 32'(rsp_valid), 0);
    checkOutput("bp_next_grant", 32'(req_ready), 32'h8);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    waitDrain();

    // Round-robin with all requesters valid (rr_ptr is 0 here)
    @(posedge clk);
    #1;
    driveReq(0, 8'h3C, 8'h0F, OP_AND);
    driveReq(1, 8'h50, 8'h05, OP_OR);
    driveReq(2, 8'hFF, 8'h01, OP_ADD);
    driveReq(3, 8'h00, 8'h01, OP_SUB);
    pushExp(0, 8'h0C, 1'b0, 1'b0);
    pushExp(1, 8'h55, 1'b0, 1'b0);
    pushExp(2, 8'h00, 1'b1, 1'b0);
    pushExp(3, 8'hFF, 1'b1, 1'b0);
    pushExp(0, 8'h0C, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (req_ready == '0 && n < 20);
      checkOutput($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << rrOrder[k]));
      gntCycle[k] = cycle;
      if (k > 0) checkOutput($sformatf("rr_spacing%0d", k),
                             32'(gntCycle[k] - gntCycle[k-1]), 3);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    waitDrain();

    // Reset mid-operation while RESP holds a response (rr_ptr is 1)
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    driveReq(1, 8'h50, 8'h05, OP_OR);
    waitGrant(1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    checkOutput("mid_rsp_valid", 32'(rsp_valid), 1);
    req_valid = '1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_req_ready", 32'(req_ready), 0);
    checkOutput("mid_reset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("mid_reset_rsp_id", 32'(rsp_id), 0);
    checkOutput("mid_reset_rsp_result", 32'(rsp_result), 0);
    checkOutput("mid_reset_rsp_carry", 32'(rsp_carry), 0);
    checkOutput("mid_reset_rsp_err", 32'(rsp_err), 0);
    expQ.delete();
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    pushExp(0, 8'h0C, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    waitDrain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one WIDTH-bit ALU (AND, OR, ADD, SUB) among NREQ requesters.
- Each requester presents operands and opcode on a valid/ready port.
- A round-robin arbiter grants one request at a time. The block computes the result and returns it on a single response port tagged with the requester ID.
- Sits between the control units and the shared arithmetic resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- req_op  in  NREQ*3  opcode; requester i occupies bits [i*3 +: 3].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that produced the response.
- rsp_result  out  WIDTH  ALU result.
- rsp_carry  out  1  carry-out (ADD) or borrow (SUB); 0 for logic ops.
- rsp_err  out  1  illegal-opcode flag (see Optional Feature).

Behaviour:
- Reset (rst_n low, any time, including mid-operation):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_err=0.
  - Any captured request is discarded.
- Opcodes:
  - 000 AND.
  - 001 OR.
  - 010 ADD: {carry,result} = a+b, computed at WIDTH+1 bits.
  - 011 SUB: result = a-b mod 2^WIDTH; carry=1 when a<b (unsigned borrow).
  - 100..111 illegal: result=0, carry=0.
- FSM, 3 states:
  - IDLE:
    - Combinationally pick the first requester with req_valid=1, scanning from rr_ptr upward with wrap from NREQ-1 to 0.
    - Drive req_ready high for that requester only.
    - The transfer occurs in the same cycle. Capture a, b, op and id into registers, set rr_ptr=(grant+1) mod NREQ, and go to EXEC.
    - If no req_valid is high, stay in IDLE and leave rr_ptr unchanged.
  - EXEC:
    - req_ready=0.
    - Compute from the captured registers and register rsp_result, rsp_carry, rsp_err and rsp_id.
    - Set rsp_valid=1 and go to RESP.
  - RESP:
    - Hold all rsp_* stable while rsp_valid=1 and rsp_ready=0.
    - When rsp_ready=1, clear rsp_valid and go to IDLE.
    - No new grant in this cycle; the next grant is earliest in the following IDLE cycle.
- Latency and throughput:
  - Request accept to rsp_valid: 2 cycles (accept in IDLE, EXEC, rsp_valid high in RESP).
  - Maximum throughput: one operation per 3 cycles.
- Requesters may hold req_valid without limit; the block never drops an unaccepted request.
- Fairness: a requester that holds req_valid is granted within NREQ grants.
- Requester inputs are sampled only on the accept cycle. Changes on other cycles have no effect.
- If rr_ptr points to a non-valid requester, the scan still wraps correctly. Example: NREQ=4, rr_ptr=3, valid=0001 grants requester 0.

Optional Feature:
- Macro: ALU_SHARE_ARB_ILLEGAL_OP_EN.
- Defined: opcodes 100..111 set rsp_err=1 with result=0 and carry=0. Legal ops give rsp_err=0.
- Undefined: the rsp_err port is still present but tied to 0. Illegal ops silently return result=0 and carry=0.

Decomposition:
- Package alu_share_pkg:
  - opcode localparams: OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b011.
  - FSM state encoding: ST_IDLE, ST_EXEC, ST_RESP (2 bits).
- One sub-module, alu_rr_pick:
  - Combinational round-robin picker.
  - Inputs: valid[NREQ], ptr[IDW].
  - Outputs: gnt_onehot[NREQ], gnt_idx[IDW], any.
- The ALU operation stays inline in EXEC.

Test Plan:
- Reset mid-operation: assert rst_n low while in RESP with rsp_valid=1 -> all outputs 0 next sample. After release, the first grant goes to requester 0 when all valid.
- Single op: NREQ=4, WIDTH=8, requester 2 sends a=8'hF0, b=8'h20, op=ADD -> 2 cycles after accept: rsp_valid=1, rsp_id=2, rsp_result=8'h10, rsp_carry=1.
- SUB borrow: a=8'h05, b=8'h07, op=SUB -> rsp_result=8'hFE, rsp_carry=1. Then a=8'h07, b=8'h05 -> rsp_result=8'h02, rsp_carry=0.
- Round-robin: all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0; one op every 3 cycles. Each req_ready pulse is exactly 1 cycle and one-hot.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready all 0. Release -> rsp_valid drops next cycle; the next grant follows in IDLE.
- Illegal op: op=3'b110, a=8'hFF, b=8'h01 -> rsp_result=0, rsp_carry=0. rsp_err=1 with ALU_SHARE_ARB_ILLEGAL_OP_EN defined; 0 without.
